rvx_bus_arbiter: RTL and testbench

- Shares one memory port between the core's instruction bus and data bus, for single-ported memory systems.
- Sits between rvx_core (ibus/dbus) and the memory/interconnect, with one transaction outstanding at a time.
- Arbitration is fixed-priority with a starvation guard; the owner's request is registered, and the response is routed back combinationally.

---
 rtl/rvx_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_rvx_bus_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvx_bus_arbiter.sv
// Fixed-priority arbiter with a starvation guard. It shares one memory port between the
// ibus and dbus of rvx_core, with one transaction in flight at a time.
`timescale 1ns/1ps
module rvx_bus_arbiter #(
   parameter bit          DBUS_PRIORITY = 1'b1,
   parameter int unsigned MAX_STREAK    = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ibus_address,
   input  logic        ibus_rrequest,
   output logic [31:0] ibus_rdata,
   output logic        ibus_rresponse,
   input  logic [31:0] dbus_address,
   input  logic        dbus_rrequest,
   input  logic        dbus_wrequest,
   input  logic [31:0] dbus_wdata,
   input  logic [3:0]  dbus_wstrobe,
   output logic [31:0] dbus_rdata,
   output logic        dbus_rresponse,
   output logic        dbus_wresponse,
   output logic [31:0] mem_address,
   output logic        mem_rrequest,
   output logic        mem_wrequest,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrobe,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rresponse,
   input  logic        mem_wresponse
);

   typedef enum logic [1:0] {IDLE, IBUS_ACTIVE, DBUS_ACTIVE} state_t;

   localparam logic [3:0] STREAK_LIMIT = 4'(MAX_STREAK);

   state_t      state, state_next;
   logic [3:0]  streak, streak_next;
   logic [31:0] address_q, wdata_q;
   logic [3:0]  wstrobe_q;
   logic        write_q;
   logic        dbus_request, prio_request, other_request;
   logic        grant_prio, grant_other, grant_dbus, grant_ibus;

   // The other bus takes the grant when the priority bus is idle or has used up its streak.
   always_comb begin
      dbus_request  = dbus_rrequest | dbus_wrequest;
      prio_request  = DBUS_PRIORITY ? dbus_request  : ibus_rrequest;
      other_request = DBUS_PRIORITY ? ibus_rrequest : dbus_request;
      grant_other   = (state == IDLE) && other_request &&
                      (!prio_request || (streak == STREAK_LIMIT));
      grant_prio    = (state == IDLE) && prio_request && !grant_other;
      grant_dbus    = DBUS_PRIORITY ? grant_prio  : grant_other;
      grant_ibus    = DBUS_PRIORITY ? grant_other : grant_prio;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         streak <= '0;
      end else begin
         state  <= state_next;
         streak <= streak_next;
      end
   end

   always_comb begin
      state_next  = state;
      streak_next = streak;
      case (state)
         IDLE: begin
            if (grant_dbus)
               state_next = DBUS_ACTIVE;
            else if (grant_ibus)
               state_next = IBUS_ACTIVE;

            if (grant_other || (grant_prio && !other_request))
               streak_next = '0;
            else if (grant_prio && (streak != STREAK_LIMIT))
               streak_next = streak + 4'd1;
         end
         IBUS_ACTIVE: begin
            if (mem_rresponse)
               state_next = IDLE;
         end
         DBUS_ACTIVE: begin
            if (write_q ? mem_wresponse : mem_rresponse)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A simultaneous read+write request from dbus is registered as a write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         address_q <= '0;
         wdata_q   <= '0;
         wstrobe_q <= '0;
         write_q   <= 1'b0;
      end else if (grant_dbus) begin
         address_q <= dbus_address;
         wdata_q   <= dbus_wdata;
         wstrobe_q <= dbus_wstrobe;
         write_q   <= dbus_wrequest;
      end else if (grant_ibus) begin
         address_q <= ibus_address;
         wdata_q   <= '0;
         wstrobe_q <= '0;
         write_q   <= 1'b0;
      end
   end

   always_comb begin
      mem_rrequest   = 1'b0;
      mem_wrequest   = 1'b0;
      ibus_rresponse = 1'b0;
      dbus_rresponse = 1'b0;
      dbus_wresponse = 1'b0;
      case (state)
         IBUS_ACTIVE: begin
            mem_rrequest   = 1'b1;
            ibus_rresponse = mem_rresponse;
         end
         DBUS_ACTIVE: begin
            mem_rrequest   = !write_q;
            mem_wrequest   = write_q;
            dbus_rresponse = mem_rresponse & !write_q;
            dbus_wresponse = mem_wresponse & write_q;
         end
         default: ;
      endcase
   end

   assign mem_address = address_q;
   assign mem_wdata   = wdata_q;
   assign mem_wstrobe = wstrobe_q;
   assign ibus_rdata  = mem_rdata;
   assign dbus_rdata  = mem_rdata;

endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Self-checking bench for rvx_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_rvx_bus_arbiter;

   localparam bit          DBUS_PRIORITY = 1'b1;
   localparam int unsigned MAX_STREAK    = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ibus_address = '0;
   logic        ibus_rrequest = 1'b0;
   logic [31:0] ibus_rdata;
   logic        ibus_rresponse;
   logic [31:0] dbus_address = '0;
   logic        dbus_rrequest = 1'b0;
   logic        dbus_wrequest = 1'b0;
   logic [31:0] dbus_wdata = '0;
   logic [3:0]  dbus_wstrobe = '0;
   logic [31:0] dbus_rdata;
   logic        dbus_rresponse;
   logic        dbus_wresponse;
   logic [31:0] mem_address;
   logic        mem_rrequest;
   logic        mem_wrequest;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrobe;
   logic [31:0] mem_rdata = '0;
   logic        mem_rresponse = 1'b0;
   logic        mem_wresponse = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   rvx_bus_arbiter #(
      .DBUS_PRIORITY(DBUS_PRIORITY),
      .MAX_STREAK   (MAX_STREAK)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .ibus_address  (ibus_address),
      .ibus_rrequest (ibus_rrequest),
      .ibus_rdata    (ibus_rdata),
      .ibus_rresponse(ibus_rresponse),
      .dbus_address  (dbus_address),
      .dbus_rrequest (dbus_rrequest),
      .dbus_wrequest (dbus_wrequest),
      .dbus_wdata    (dbus_wdata),
      .dbus_wstrobe  (dbus_wstrobe),
      .dbus_rdata    (dbus_rdata),
      .dbus_rresponse(dbus_rresponse),
      .dbus_wresponse(dbus_wresponse),
      .mem_address   (mem_address),
      .mem_rrequest  (mem_rrequest),
      .mem_wrequest  (mem_wrequest),
      .mem_wdata     (mem_wdata),
      .mem_wstrobe   (mem_wstrobe),
      .mem_rdata     (mem_rdata),
      .mem_rresponse (mem_rresponse),
      .mem_wresponse (mem_wresponse)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      vectors++; if ({mem_rrequest, mem_wrequest} !== 2'b00) begin miscompares++; $display("FAIL reset_mem_req: got %b want 00", {mem_rrequest, mem_wrequest}); end
      vectors++; if (mem_address !== 32'h0) begin miscompares++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
      vectors++; if ({mem_wdata, mem_wstrobe} !== 36'h0) begin miscompares++; $display("FAIL reset_mem_wdata_strobe: got %h/%h want 0/0", mem_wdata, mem_wstrobe); end
      vectors++; if ({ibus_rresponse, dbus_rresponse, dbus_wresponse} !== 3'b000) begin miscompares++; $display("FAIL reset_upstream_resp: got %b want 000", {ibus_rresponse, dbus_rresponse, dbus_wresponse}); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      ibus_rrequest = 1'b1;
      ibus_address  = 32'h0000_0100;
      tick();
      vectors++; if ({mem_rrequest, mem_wrequest} !== 2'b10) begin miscompares++; $display("FAIL single_mem_req: got %b want 10", {mem_rrequest, mem_wrequest}); end
      vectors++; if (mem_address !== 32'h100) begin miscompares++; $display("FAIL single_mem_address: got %h want 00000100", mem_address); end
      tick();
      vectors++; if ({ibus_rresponse, mem_rrequest} !== 2'b01) begin miscompares++; $display("FAIL single_wait: got resp/req %b want 01", {ibus_rresponse, mem_rrequest}); end
      tick();
      mem_rresponse = 1'b1;
      mem_rdata     = 32'hDEAD_BEEF;
      #1;
      vectors++; if (ibus_rresponse !== 1'b1) begin miscompares++; $display("FAIL single_ibus_resp: got %b want 1", ibus_rresponse); end
      vectors++; if (ibus_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_ibus_rdata: got %h want deadbeef", ibus_rdata); end
      vectors++; if ({dbus_rresponse, dbus_wresponse} !== 2'b00) begin miscompares++; $display("FAIL single_dbus_quiet: got %b want 00", {dbus_rresponse, dbus_wresponse}); end
      tick();
      mem_rresponse = 1'b0;
      ibus_rrequest = 1'b0;
      #1;
      vectors++; if ({mem_rrequest, ibus_rresponse} !== 2'b00) begin miscompares++; $display("FAIL single_back_idle: got req/resp %b want 00", {mem_rrequest, ibus_rresponse}); end
   endtask

   task automatic test_priority();
      logic [31:0] rd;
      ibus_rrequest = 1'b1;
      ibus_address  = 32'h0;
      dbus_wrequest = 1'b1;
      dbus_address  = 32'h2000;
      dbus_wdata    = 32'h1234_5678;
      dbus_wstrobe  = 4'hF;
      tick();
      vectors++; if ({mem_rrequest, mem_wrequest} !== 2'b01) begin miscompares++; $display("FAIL prio_dbus_first: got %b want 01", {mem_rrequest, mem_wrequest}); end
      vectors++; if ({mem_address, mem_wdata, mem_wstrobe} !== {32'h2000, 32'h1234_5678, 4'hF}) begin miscompares++; $display("FAIL prio_dbus_fields: got %h/%h/%h want 00002000/12345678/f", mem_address, mem_wdata, mem_wstrobe); end
      mem_wresponse = 1'b1;
      #1;
      vectors++; if ({ibus_rresponse, dbus_rresponse, dbus_wresponse} !== 3'b001) begin miscompares++; $display("FAIL prio_dbus_wresp: got %b want 001", {ibus_rresponse, dbus_rresponse, dbus_wresponse}); end
      tick();
      mem_wresponse = 1'b0;
      dbus_wrequest = 1'b0;
      vectors++; if ({mem_rrequest, mem_wrequest} !== 2'b00) begin miscompares++; $display("FAIL prio_pass_idle: got %b want 00", {mem_rrequest, mem_wrequest}); end
      tick();
      vectors++; if ({mem_rrequest, mem_wrequest, mem_address} !== {2'b10, 32'h0}) begin miscompares++; $display("FAIL prio_ibus_second: got req %b addr %h want 10 addr 0", {mem_rrequest, mem_wrequest}, mem_address); end
      rd            = $urandom;
      mem_rdata     = rd;
      mem_rresponse = 1'b1;
      #1;
      vectors++; if ({ibus_rresponse, ibus_rdata} !== {1'b1, rd}) begin miscompares++; $display("FAIL prio_ibus_resp: got %b/%h want 1/%h", ibus_rresponse, ibus_rdata, rd); end
      tick();
      mem_rresponse = 1'b0;
      ibus_rrequest = 1'b0;
   endtask

   task automatic test_streak();
      byte want[7] = '{"D", "D", "D", "D", "I", "D", "D"};
      byte got[7]  = '{0, 0, 0, 0, 0, 0, 0};
      int  n       = 0;
      int  dcount  = 0;
      bit  d_done  = 1'b0;
      ibus_rrequest = 1'b1;
      ibus_address  = 32'h1000;
      dbus_rrequest = 1'b1;
      dbus_address  = 32'h3000;
      for (int cyc = 0; cyc < 100 && n < 7; cyc++) begin
         tick();
         mem_rresponse = 1'b0;
         if (d_done) begin
            dcount++;
            d_done = 1'b0;
            if (dcount == 6) dbus_rrequest = 1'b0;
            else             dbus_address  = 32'h3000 + 32'(dcount * 4);
         end
         if (mem_rrequest) begin
            got[n]        = (mem_address == 32'h1000) ? "I" : "D";
            d_done        = (mem_address != 32'h1000);
            n++;
            mem_rdata     = $urandom;
            mem_rresponse = 1'b1;
         end
      end
      for (int k = 0; k < 7; k++) begin
         vectors++; if (got[k] !== want[k]) begin miscompares++; $display("FAIL streak_grant_%0d: got '%c' want '%c'", k, got[k], want[k]); end
      end
      tick();
      mem_rresponse = 1'b0;
      ibus_rrequest = 1'b0;
      dbus_rrequest = 1'b0;
      tick();
   endtask

   task automatic test_rw_both();
      dbus_rrequest = 1'b1;
      dbus_wrequest = 1'b1;
      dbus_address  = 32'h40;
      dbus_wdata    = 32'hA5A5_0F0F;
      dbus_wstrobe  = 4'h3;
      tick();
      vectors++; if ({mem_rrequest, mem_wrequest, mem_address} !== {2'b01, 32'h40}) begin miscompares++; $display("FAIL rw_as_write: got req %b addr %h want 01 addr 40", {mem_rrequest, mem_wrequest}, mem_address); end
      mem_wresponse = 1'b1;
      #1;
      vectors++; if ({dbus_rresponse, dbus_wresponse} !== 2'b01) begin miscompares++; $display("FAIL rw_resp: got r/w %b want 01", {dbus_rresponse, dbus_wresponse}); end
      tick();
      mem_wresponse = 1'b0;
      dbus_rrequest = 1'b0;
      dbus_wrequest = 1'b0;
      #1;
      vectors++; if ({mem_rrequest, mem_wrequest, dbus_rresponse, dbus_wresponse} !== 4'b0000) begin miscompares++; $display("FAIL rw_idle: got %b want 0000", {mem_rrequest, mem_wrequest, dbus_rresponse, dbus_wresponse}); end
   endtask

   task automatic test_reset_mid();
      dbus_rrequest = 1'b1;
      dbus_address  = 32'h80;
      dbus_wdata    = 32'h5555_AAAA;
      dbus_wstrobe  = 4'h9;
      tick();
      vectors++; if ({mem_rrequest, mem_address} !== {1'b1, 32'h80}) begin miscompares++; $display("FAIL rstmid_active: got %b/%h want 1/00000080", mem_rrequest, mem_address); end
      #2 reset = 1'b1;
      #1;
      vectors++; if ({mem_rrequest, mem_wrequest, mem_address, mem_wdata, mem_wstrobe} !== 70'h0) begin miscompares++; $display("FAIL rstmid_mem_clear: got %b %b %h %h %h want all 0", mem_rrequest, mem_wrequest, mem_address, mem_wdata, mem_wstrobe); end
      mem_rresponse = 1'b1;
      mem_rdata     = 32'hCAFE_0001;
      #1;
      vectors++; if ({ibus_rresponse, dbus_rresponse, dbus_wresponse} !== 3'b000) begin miscompares++; $display("FAIL rstmid_resp_during: got %b want 000", {ibus_rresponse, dbus_rresponse, dbus_wresponse}); end
      tick();
      reset = 1'b0;
      #1;
      vectors++; if ({ibus_rresponse, dbus_rresponse, dbus_wresponse, mem_rrequest} !== 4'b0000) begin miscompares++; $display("FAIL rstmid_resp_after: got %b want 0000", {ibus_rresponse, dbus_rresponse, dbus_wresponse, mem_rrequest}); end
      tick();
      mem_rresponse = 1'b0;
      vectors++; if ({mem_rrequest, mem_address} !== {1'b1, 32'h80}) begin miscompares++; $display("FAIL rstmid_regrant: got %b/%h want 1/00000080", mem_rrequest, mem_address); end
      mem_rdata     = 32'h0BAD_F00D;
      mem_rresponse = 1'b1;
      #1;
      vectors++; if ({dbus_rresponse, dbus_rdata} !== {1'b1, 32'h0BAD_F00D}) begin miscompares++; $display("FAIL rstmid_regrant_resp: got %b/%h want 1/0badf00d", dbus_rresponse, dbus_rdata); end
      tick();
      mem_rresponse = 1'b0;
      dbus_rrequest = 1'b0;
   endtask

   task automatic test_unexpected();
      tick();
      mem_rresponse = 1'b1;
      mem_wresponse = 1'b1;
      #1;
      vectors++; if ({ibus_rresponse, dbus_rresponse, dbus_wresponse} !== 3'b000) begin miscompares++; $display("FAIL unexp_idle_resp: got %b want 000", {ibus_rresponse, dbus_rresponse, dbus_wresponse}); end
      tick();
      mem_rresponse = 1'b0;
      mem_wresponse = 1'b0;
      vectors++; if ({mem_rrequest, mem_wrequest} !== 2'b00) begin miscompares++; $display("FAIL unexp_idle_state: got %b want 00", {mem_rrequest, mem_wrequest}); end
      ibus_rrequest = 1'b1;
      ibus_address  = 32'h200;
      tick();
      mem_wresponse = 1'b1;
      #1;
      vectors++; if ({ibus_rresponse, dbus_rresponse, dbus_wresponse} !== 3'b000) begin miscompares++; $display("FAIL unexp_wresp_ibus: got %b want 000", {ibus_rresponse, dbus_rresponse, dbus_wresponse}); end
      tick();
      mem_wresponse = 1'b0;
      vectors++; if ({mem_rrequest, mem_address} !== {1'b1, 32'h200}) begin miscompares++; $display("FAIL unexp_still_active: got %b/%h want 1/00000200", mem_rrequest, mem_address); end
      mem_rdata     = 32'h1357_9BDF;
      mem_rresponse = 1'b1;
      #1;
      vectors++; if ({ibus_rresponse, ibus_rdata} !== {1'b1, 32'h1357_9BDF}) begin miscompares++; $display("FAIL unexp_final_resp: got %b/%h want 1/13579bdf", ibus_rresponse, ibus_rdata); end
      tick();
      mem_rresponse = 1'b0;
      ibus_rrequest = 1'b0;
   endtask

   task automatic test_random();
      int          m_owner  = 0;   // 0 none, 1 ibus, 2 dbus
      int          m_streak = 0;
      logic [31:0] e_addr   = '0;
      logic [31:0] e_wdata  = '0;
      logic [3:0]  e_strobe = '0;
      bit          e_write  = 1'b0;
      bit          i_done   = 1'b0;
      bit          d_done   = 1'b0;
      bit          mem_busy = 1'b0;
      int          mem_wait = 0;
      int          grants   = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(posedge clock);
         #1;
         if (i_done) begin ibus_rrequest = 1'b0; i_done = 1'b0; end
         if (d_done) begin dbus_rrequest = 1'b0; dbus_wrequest = 1'b0; d_done = 1'b0; end
         if (!ibus_rrequest && $urandom_range(0, 2) != 0) begin
            ibus_rrequest = 1'b1;
            ibus_address  = $urandom & 32'hFFFF_FFFC;
         end
         if (!(dbus_rrequest || dbus_wrequest) && $urandom_range(0, 3) != 0) begin
            int kind = $urandom_range(0, 2);
            dbus_rrequest = (kind != 1);
            dbus_wrequest = (kind != 0);
            dbus_address  = $urandom & 32'hFFFF_FFFC;
            dbus_wdata    = $urandom;
            dbus_wstrobe  = 4'($urandom);
         end
         mem_rresponse = 1'b0;
         mem_wresponse = 1'b0;
         mem_rdata     = $urandom;
         if (mem_rrequest || mem_wrequest) begin
            if (!mem_busy) begin mem_busy = 1'b1; mem_wait = $urandom_range(0, 3); end
            if (mem_wait == 0) begin
               mem_rresponse = mem_rrequest;
               mem_wresponse = mem_wrequest;
               mem_busy      = 1'b0;
            end else begin
               mem_wait--;
            end
         end
         if ($urandom_range(0, 7) == 0) begin
            if (!mem_rrequest)      mem_rresponse = 1'b1;
            else if (!mem_wrequest) mem_wresponse = 1'b1;
         end

         @(negedge clock);
         if (m_owner == 0) begin
            bit dreq, both, d_wins;
            vectors++; if ({mem_rrequest, mem_wrequest} !== 2'b00) begin miscompares++; $display("FAIL rand_idle_req @%0d: got %b want 00", cyc, {mem_rrequest, mem_wrequest}); end
            vectors++; if ({ibus_rresponse, dbus_rresponse, dbus_wresponse} !== 3'b000) begin miscompares++; $display("FAIL rand_idle_resp @%0d: got %b want 000", cyc, {ibus_rresponse, dbus_rresponse, dbus_wresponse}); end
            dreq = dbus_rrequest || dbus_wrequest;
            both = dreq && ibus_rrequest;
            if (dreq || ibus_rrequest) begin
               if (!dreq)              d_wins = 1'b0;
               else if (!ibus_rrequest) d_wins = 1'b1;
               else                    d_wins = (m_streak == MAX_STREAK) ? !DBUS_PRIORITY : DBUS_PRIORITY;
               if (d_wins == DBUS_PRIORITY) m_streak = both ? ((m_streak < MAX_STREAK) ? m_streak + 1 : m_streak) : 0;
               else                         m_streak = 0;
               m_owner  = d_wins ? 2 : 1;
               e_addr   = d_wins ? dbus_address : ibus_address;
               e_write  = d_wins && dbus_wrequest;
               e_wdata  = dbus_wdata;
               e_strobe = dbus_wstrobe;
               grants++;
            end
         end else begin
            bit done;
            vectors++; if ({mem_rrequest, mem_wrequest} !== {!e_write, e_write}) begin miscompares++; $display("FAIL rand_active_req @%0d: got %b want %b", cyc, {mem_rrequest, mem_wrequest}, {!e_write, e_write}); end
            vectors++; if (mem_address !== e_addr) begin miscompares++; $display("FAIL rand_address @%0d: got %h want %h (owner %0d)", cyc, mem_address, e_addr, m_owner); end
            if (e_write) begin
               vectors++; if ({mem_wdata, mem_wstrobe} !== {e_wdata, e_strobe}) begin miscompares++; $display("FAIL rand_wfields @%0d: got %h/%h want %h/%h", cyc, mem_wdata, mem_wstrobe, e_wdata, e_strobe); end
            end
            done = e_write ? mem_wresponse : mem_rresponse;
            vectors++; if ({ibus_rresponse, dbus_rresponse, dbus_wresponse} !== {done && m_owner == 1, done && m_owner == 2 && !e_write, done && m_owner == 2 && e_write}) begin
               miscompares++; $display("FAIL rand_resp @%0d: got %b want %b", cyc, {ibus_rresponse, dbus_rresponse, dbus_wresponse}, {done && m_owner == 1, done && m_owner == 2 && !e_write, done && m_owner == 2 && e_write});
            end
            if (done && !e_write) begin
               vectors++; if ((m_owner == 1 ? ibus_rdata : dbus_rdata) !== mem_rdata) begin miscompares++; $display("FAIL rand_rdata @%0d: got %h want %h", cyc, (m_owner == 1 ? ibus_rdata : dbus_rdata), mem_rdata); end
            end
            if (done) begin
               if (m_owner == 1) i_done = 1'b1;
               else              d_done = 1'b1;
               m_owner = 0;
            end
         end
      end
      vectors++; if (grants < 50) begin miscompares++; $display("FAIL rand_progress: got %0d grants want >= 50", grants); end
      tick();
      ibus_rrequest = 1'b0;
      dbus_rrequest = 1'b0;
      dbus_wrequest = 1'b0;
      mem_rresponse = 1'b0;
      mem_wresponse = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_priority();
      test_streak();
      test_rw_both();
      test_reset_mid();
      test_unexpected();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      miscompares++;
      $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule
